// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store unit.
//   - API address/data widths
//   - request size encodings (byte/half/word/illegal)
//   - LSU FSM state encodings
//   - helpers: alignment/legality check, last store beat index, lane one-hot mask
package mem_lsu_pkg;

   localparam int unsigned ApiAddrWidth = 32;
   localparam int unsigned ApiDataWidth = 32;

   typedef enum logic [1:0] {
      LsuSizeB = 2'b00,
      LsuSizeH = 2'b01,
      LsuSizeW = 2'b10,
      LsuSizeX = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      LsuIdle  = 2'b00,
      LsuStore = 2'b01,
      LsuLoad  = 2'b10,
      LsuResp  = 2'b11
   } lsu_state_e;

   // Misaligned half/word or the reserved size encoding.
   function automatic logic lsu_req_bad(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         LsuSizeB: bad = 1'b0;
         LsuSizeH: bad = offset[0];
         LsuSizeW: bad = (offset != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Index of the final one-byte store beat (N-1 for N = 1/2/4).
   function automatic logic [1:0] lsu_last_beat(input logic [1:0] size);
      logic [1:0] last;
      case (size)
         LsuSizeB: last = 2'd0;
         LsuSizeH: last = 2'd1;
         default:  last = 2'd3;
      endcase
      return last;
   endfunction

   function automatic logic [3:0] lsu_lane_mask(input logic [1:0] lane);
      logic [3:0] mask;
      mask = 4'b0001 << lane;
      return mask;
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend: combinational load-data extraction and extension.
//   word_i     - full 32-bit RAM word
//   offset_i   - byte address bits [1:0]
//   size_i     - 00 byte, 01 half, 10 word
//   unsigned_i - zero-extend byte/half results (ignored for word)
//   result_o   - right-justified, extended load result
module mem_load_extend
   import mem_lsu_pkg::*;
(
   input  logic [ApiDataWidth-1:0] word_i,
   input  logic [1:0]              offset_i,
   input  logic [1:0]              size_i,
   input  logic                    unsigned_i,
   output logic [ApiDataWidth-1:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign_bit;

   always_comb begin
      byte_sel = word_i[{offset_i, 3'b000} +: 8];
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
      sign_bit = 1'b0;
      result_o = word_i;
      case (size_i)
         LsuSizeB: begin
            sign_bit = byte_sel[7] & ~unsigned_i;
            result_o = {{24{sign_bit}}, byte_sel};
         end
         LsuSizeH: begin
            sign_bit = half_sel[15] & ~unsigned_i;
            result_o = {{16{sign_bit}}, half_sel};
         end
         default: result_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the execute stage and mem_RAM.
// One request in flight. Stores are split into one-byte-lane beats because the RAM
// writes data_in[7:0] into every enabled lane; loads are lane-extracted and extended.
// Misaligned or illegal requests answer with an error and never touch the RAM.
//   clk, reset_n              - clock, asynchronous active-low reset
//   req_valid_i / req_ready_o - request handshake (accepted in IDLE only)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i - request fields
//   resp_valid_o              - one-cycle completion pulse
//   resp_rdata_o, resp_err_o  - load result / error flag, valid with resp_valid_o
//   ram_en_o, ram_address_o, ram_data_o, ram_wr_mask_o - RAM drive (all registered)
//   ram_data_i                - RAM read data
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [1:0]              req_size_i,
   input  logic                    req_unsigned_i,
   input  logic [ApiAddrWidth-1:0] req_addr_i,
   input  logic [ApiDataWidth-1:0] req_wdata_i,
   output logic                    resp_valid_o,
   output logic [ApiDataWidth-1:0] resp_rdata_o,
   output logic                    resp_err_o,
   output logic                    ram_en_o,
   output logic [ApiAddrWidth-1:0] ram_address_o,
   output logic [ApiDataWidth-1:0] ram_data_o,
   output logic [3:0]              ram_wr_mask_o,
   input  logic [ApiDataWidth-1:0] ram_data_i
);

   lsu_state_e              state_q;
   logic [ApiAddrWidth-1:0] addr_q;
   logic [ApiDataWidth-1:0] wdata_q;
   logic [1:0]              size_q;
   logic                    unsigned_q;
   logic                    we_q;
   logic [1:0]              lane_q;
   logic [1:0]              beat_q;

   logic                    ready_q;
   logic                    resp_valid_q;
   logic                    resp_err_q;
   logic [ApiDataWidth-1:0] rdata_q;
   logic                    ram_en_q;
   logic [ApiAddrWidth-1:0] ram_addr_q;
   logic [ApiDataWidth-1:0] ram_data_q;
   logic [3:0]              ram_mask_q;

   logic                    req_bad;
   logic [1:0]              next_lane;
   logic [1:0]              next_beat;
   logic [7:0]              next_byte;
   logic [ApiDataWidth-1:0] load_ext;

   mem_load_extend u_load_extend (
      .word_i     (ram_data_i),
      .offset_i   (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .result_o   (load_ext)
   );

   always_comb begin
      req_bad   = lsu_req_bad(req_size_i, req_addr_i[1:0]);
      next_lane = lane_q + 2'd1;
      next_beat = beat_q + 2'd1;
      next_byte = wdata_q[{next_beat, 3'b000} +: 8];
   end

   // Every output is a flop loaded one cycle ahead, so each RAM beat is held stable for
   // a full cycle (seen by the RAM at the negedge and again at the following posedge).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= LsuIdle;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         we_q         <= 1'b0;
         lane_q       <= 2'd0;
         beat_q       <= 2'd0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= '0;
         ram_en_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ram_mask_q   <= 4'b0000;
      end else begin
         unique case (state_q)
            LsuIdle: begin
               if (req_valid_i && ready_q) begin
                  addr_q     <= req_addr_i;
                  wdata_q    <= req_wdata_i;
                  size_q     <= req_size_i;
                  unsigned_q <= req_unsigned_i;
                  we_q       <= req_we_i;
                  lane_q     <= req_addr_i[1:0];
                  beat_q     <= 2'd0;
                  ready_q    <= 1'b0;
                  rdata_q    <= '0;
                  if (req_bad) begin
                     state_q      <= LsuResp;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else begin
                     ram_en_q   <= 1'b1;
                     ram_addr_q <= {req_addr_i[ApiAddrWidth-1:2], 2'b00};
                     if (req_we_i) begin
                        // First beat goes out right away: byte 0 into lane addr[1:0].
                        state_q    <= LsuStore;
                        ram_mask_q <= lsu_lane_mask(req_addr_i[1:0]);
                        ram_data_q <= {24'h0, req_wdata_i[7:0]};
                     end else begin
                        state_q    <= LsuLoad;
                        ram_mask_q <= 4'b0000;
                        ram_data_q <= '0;
                     end
                  end
               end
            end

            LsuStore: begin
               if (beat_q == lsu_last_beat(size_q)) begin
                  state_q      <= LsuResp;
                  resp_valid_q <= 1'b1;
                  ram_en_q     <= 1'b0;
                  ram_addr_q   <= '0;
                  ram_data_q   <= '0;
                  ram_mask_q   <= 4'b0000;
               end else begin
                  beat_q     <= next_beat;
                  lane_q     <= next_lane;
                  ram_addr_q <= {addr_q[ApiAddrWidth-1:2], 2'b00};
                  ram_mask_q <= lsu_lane_mask(next_lane);
                  ram_data_q <= {24'h0, next_byte};
               end
            end

            LsuLoad: begin
               if (!we_q) begin
                  rdata_q <= load_ext;
               end
               state_q      <= LsuResp;
               resp_valid_q <= 1'b1;
               ram_en_q     <= 1'b0;
               ram_addr_q   <= '0;
               ram_data_q   <= '0;
               ram_mask_q   <= 4'b0000;
            end

            LsuResp: begin
               state_q      <= LsuIdle;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               rdata_q      <= '0;
               ready_q      <= 1'b1;
            end

            default: state_q <= LsuIdle;
         endcase
      end
   end

   assign req_ready_o   = ready_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_err_o    = resp_err_q;
   assign resp_rdata_o  = rdata_q;
   assign ram_en_o      = ram_en_q;
   assign ram_address_o = ram_addr_q;
   assign ram_data_o    = ram_data_q;
   assign ram_wr_mask_o = ram_mask_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a small byte-lane RAM model.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        ram_en_o;
   logic [31:0] ram_address_o;
   logic [31:0] ram_data_o;
   logic [3:0]  ram_wr_mask_o;
   logic [31:0] ram_data_i;

   mem_lsu dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .resp_valid_o   (resp_valid_o),
      .resp_rdata_o   (resp_rdata_o),
      .resp_err_o     (resp_err_o),
      .ram_en_o       (ram_en_o),
      .ram_address_o  (ram_address_o),
      .ram_data_o     (ram_data_o),
      .ram_wr_mask_o  (ram_wr_mask_o),
      .ram_data_i     (ram_data_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: writes data[7:0] into every enabled lane, clears on reset.
   logic [31:0] mem [16];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (ram_en_o) begin
         for (int l = 0; l < 4; l++)
            if (ram_wr_mask_o[l]) mem[ram_address_o[5:2]][8*l +: 8] <= ram_data_o[7:0];
      end
   end
   assign ram_data_i = ram_en_o ? mem[ram_address_o[5:2]] : 32'h0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } beat_t;

   resp_t resp_q[$];
   beat_t beat_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int last_resp = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every response pulse and every RAM cycle against the queues.
   always @(negedge clk) begin
      if (reset_n) begin
         if (resp_valid_o) begin
            if (resp_q.size() == 0) begin
               check("resp_unexpected", resp_valid_o, 1'b0);
            end else begin
               resp_t e;
               e = resp_q.pop_front();
               check("resp_rdata", resp_rdata_o, e.rdata);
               check("resp_err", resp_err_o, e.err);
               check("resp_latency", cyc - e.acc + 1, e.lat);
               check("ready_low_in_resp", req_ready_o, 1'b0);
               last_resp = cyc;
            end
         end
         if (ram_en_o) begin
            if (beat_q.size() == 0) begin
               check("ram_unexpected", ram_en_o, 1'b0);
            end else begin
               beat_t b;
               b = beat_q.pop_front();
               check("ram_address", ram_address_o, b.addr);
               check("ram_data", ram_data_o, b.data);
               check("ram_wr_mask", ram_wr_mask_o, b.mask);
            end
         end else begin
            check("ram_idle_zero", {ram_address_o, ram_data_o, ram_wr_mask_o}, '0);
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      check(name, {req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, ram_en_o,
                   ram_address_o, ram_data_o, ram_wr_mask_o}, {1'b1, 103'b0});
   endtask

   // Drive one request, wait (bounded) for acceptance, push expected response and beats.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input logic hold, output int acc, output int nlow);
      resp_t r;
      beat_t b;
      int nb;
      logic [1:0] lane;
      @(negedge clk);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      nlow = 0;
      while (!req_ready_o && nlow < 40) begin
         @(negedge clk);
         nlow++;
      end
      if (!req_ready_o) begin
         check("accept_timeout", req_ready_o, 1'b1);
         req_valid_i = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      r.rdata = exp_rdata;
      r.err   = exp_err;
      r.lat   = exp_lat;
      r.acc   = acc;
      resp_q.push_back(r);
      if (!exp_err) begin
         if (we) begin
            nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            for (int i = 0; i < nb; i++) begin
               lane   = addr[1:0] + 2'(i);
               b.addr = {addr[31:2], 2'b00};
               b.data = {24'h0, wdata[8*i +: 8]};
               b.mask = 4'b0001 << lane;
               beat_q.push_back(b);
            end
         end else begin
            b.addr = {addr[31:2], 2'b00};
            b.data = '0;
            b.mask = 4'b0000;
            beat_q.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((resp_q.size() != 0 || beat_q.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_resp", resp_q.size(), 0);
      check("drain_beats", beat_q.size(), 0);
   endtask

   initial begin
      int acc1, acc2, nlow;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset_state");
      reset_n = 1'b1;

      // Word store then readback / lane extraction.
      issue(1, 2'b10, 0, 32'h8, 32'hAABBCCDD, 32'h0,        0, 5, 0, acc1, nlow);
      issue(0, 2'b10, 0, 32'h8, 32'h0,       32'hAABBCCDD, 0, 2, 0, acc1, nlow);
      issue(0, 2'b00, 0, 32'hB, 32'h0,       32'hFFFFFFAA, 0, 2, 0, acc1, nlow);
      issue(0, 2'b00, 1, 32'hB, 32'h0,       32'h000000AA, 0, 2, 0, acc1, nlow);
      issue(0, 2'b01, 0, 32'hA, 32'h0,       32'hFFFFAABB, 0, 2, 0, acc1, nlow);
      issue(0, 2'b01, 1, 32'h8, 32'h0,       32'h0000CCDD, 0, 2, 0, acc1, nlow);
      issue(0, 2'b10, 1, 32'h8, 32'h0,       32'hAABBCCDD, 0, 2, 0, acc1, nlow);

      // Half store into the upper lanes.
      issue(1, 2'b01, 0, 32'h6, 32'hDEAD1234, 32'h0,        0, 3, 0, acc1, nlow);
      issue(0, 2'b10, 0, 32'h4, 32'h0,        32'h12340000, 0, 2, 0, acc1, nlow);

      // Byte stores and signed/unsigned byte loads.
      issue(1, 2'b00, 0, 32'h11, 32'h0000005A, 32'h0,        0, 2, 0, acc1, nlow);
      issue(1, 2'b00, 0, 32'h12, 32'hFFFFFF80, 32'h0,        0, 2, 0, acc1, nlow);
      issue(0, 2'b00, 0, 32'h11, 32'h0,        32'h0000005A, 0, 2, 0, acc1, nlow);
      issue(0, 2'b00, 0, 32'h12, 32'h0,        32'hFFFFFF80, 0, 2, 0, acc1, nlow);
      issue(0, 2'b00, 1, 32'h12, 32'h0,        32'h00000080, 0, 2, 0, acc1, nlow);

      // Misaligned / illegal: error after one cycle, no RAM traffic.
      issue(1, 2'b10, 0, 32'h5, 32'h55555555, 32'h0, 1, 1, 0, acc1, nlow);
      issue(0, 2'b01, 0, 32'h3, 32'h0,        32'h0, 1, 1, 0, acc1, nlow);
      issue(0, 2'b11, 0, 32'h0, 32'h0,        32'h0, 1, 1, 0, acc1, nlow);
      issue(0, 2'b10, 0, 32'h4, 32'h0,        32'h12340000, 0, 2, 0, acc1, nlow);

      // Back-to-back with req_valid_i held high.
      issue(0, 2'b10, 0, 32'h8, 32'h0, 32'hAABBCCDD, 0, 2, 1, acc1, nlow);
      issue(0, 2'b00, 1, 32'h8, 32'h0, 32'h000000DD, 0, 2, 0, acc2, nlow);
      check("b2b_ready_low_cycles", nlow, 2);
      check("b2b_accept_spacing", acc2 - acc1, 3);
      check("b2b_accept_after_resp", acc2 - last_resp, 2);
      drain();

      // Reset during beat 2 of a word store.
      issue(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 5, 0, acc1, nlow);
      nlow = 0;
      while (ram_wr_mask_o != 4'b0100 && nlow < 10) begin
         @(negedge clk);
         nlow++;
      end
      check("reset_test_beat2_seen", ram_wr_mask_o, 4'b0100);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset_mid_store");
      resp_q.delete();
      beat_q.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_held");
      reset_n = 1'b1;
      issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 2, 0, acc1, nlow);
      issue(1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 32'h0, 0, 5, 0, acc1, nlow);
      issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFCAFE, 0, 2, 0, acc1, nlow);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
